apb_master: RTL
===============

# apb_master

APB initiator that converts a simple valid/ready command stream into APB3 transfers and returns one response per command. It is the requester-side counterpart to the team's APB register slaves and drives PSEL/PENABLE/PADDR/PWRITE/PWDATA toward a single slave or decoder. It supports PREADY wait states, PSLVERR reporting and an optional access timeout. It is used in simulation benches and as a synthesizable register-access engine.

## Interface
- ADR_W, 32, APB address width
- DAT_W, 32, APB data width
- TIMEOUT, 256, maximum ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout; must be less than 2^16
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset; one clock, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADR_W  byte address
- cmd_wdata  in  DAT_W  write data (ignored for reads)
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DAT_W  read data; 0 for writes and aborted transfers
- rsp_err  out  1  PSLVERR at completion, or 1 on timeout
- rsp_timeout  out  1  1 = transfer aborted by timeout
- PADDR, PSEL, PENABLE, PWRITE, PWDATA  out  ADR_W/1/1/1/DAT_W  APB requester outputs
- PRDATA, PREADY, PSLVERR  in  DAT_W/1/1  APB completer inputs

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - cmd_ready = 1 only in IDLE.
  - On handshake: latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA; clear wait counter; go to SETUP.
- SETUP
  - PSEL = 1, PENABLE = 0.
  - Go unconditionally to ACCESS.
- ACCESS
  - PSEL = 1, PENABLE = 1.
  - PREADY = 1: complete the transfer.
    - rsp_rdata = PRDATA if read, else 0.
    - rsp_err = PSLVERR, rsp_timeout = 0.
    - Go to RESP.
  - PREADY = 0: increment the 16-bit wait counter.
    - If TIMEOUT ≠ 0 and the counter reaches TIMEOUT: abort with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; go to RESP.
- RESP
  - PSEL = 0, PENABLE = 0, rsp_valid = 1.
  - rsp_* held stable until rsp_ready; on rsp_ready go to IDLE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. They keep their last value in RESP and IDLE.
- PSLVERR and PRDATA are sampled only in the ACCESS cycle with PREADY = 1. They are ignored otherwise.
- One outstanding transfer at a time. No command queueing.
- Reset (PRESET = 1 at a clock edge, any state):
  - Go to IDLE.
  - All outputs 0 from the next edge, except cmd_ready = 1 once PRESET is deasserted.
  - An in-flight transfer is dropped with no response.
  - PSEL falls mid-transfer; this is accepted behaviour.

## Timing
- Reset values: PSEL = PENABLE = PWRITE = 0, PADDR = 0, PWDATA = 0, rsp_valid = rsp_err = rsp_timeout = 0, rsp_rdata = 0, cmd_ready = 0 while PRESET = 1.
- Edge numbering: handshake at edge N → SETUP cycle N..N+1 → ACCESS from edge N+1.
  - Zero wait states: PREADY sampled high at edge N+2; rsp_valid = 1 after edge N+2.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- With rsp_ready held high, RESP lasts one cycle and cmd_ready returns after edge N+3. Minimum command period is 4 cycles.
- Timeout: with TIMEOUT = T and PREADY stuck low, the abort is taken at the T-th low sample, i.e. edge N+1+T. rsp_valid is seen after that edge.
- PREADY high on the same edge that the counter reaches T: normal completion wins; rsp_timeout = 0.
- cmd_valid changes while not in IDLE are ignored. The command bus is sampled only at the IDLE handshake.

## Test plan
- Write, zero wait: cmd {write, addr 0x0000_0004, data 0xDEAD_BEEF}.
  - SETUP then ACCESS with PADDR = 0x4, PWDATA = 0xDEAD_BEEF, PWRITE = 1.
  - rsp_valid 2 cycles after handshake; rsp_err = 0; rsp_rdata = 0.
- Read with 3 wait states: PREADY low for 3 ACCESS cycles, PRDATA = 0x1234_5678 on the high cycle.
  - rsp_rdata = 0x1234_5678, rsp_valid 5 cycles after handshake.
  - PADDR, PSEL and PENABLE stable throughout.
- Slave error: read addr 0x0000_0040 with PSLVERR = 1 on completion → rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0x1234_5678 passed through.
- Timeout: TIMEOUT = 8, PREADY stuck 0 → abort at the 8th low ACCESS sample.
  - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - PSEL = 0 in RESP; next command accepted normally.
- Response backpressure: rsp_ready low for 5 cycles.
  - rsp_* stable, cmd_ready = 0 and PSEL = 0 throughout.
  - Back-to-back writes with rsp_ready = 1: one handshake every 4 cycles.
- Reset mid-ACCESS: assert PRESET for 1 cycle during a waited read.
  - Next edge: PSEL = PENABLE = 0, no rsp_valid, state IDLE.
  - A following read completes normally.

Source files
------------

// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command stream into single APB transfers
// and returns one response per command, with wait-state and timeout handling.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command handshake
// SETUP  | PSEL high, PENABLE low, address phase
// ACCESS | PSEL and PENABLE high, waiting for PREADY or the timeout
// RESP   | bus released, response held until rsp_ready
module apb_master #(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [ADR_W-1:0] cmd_addr,
  input  logic [DAT_W-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             rsp_timeout,
  output logic [ADR_W-1:0] PADDR,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [DAT_W-1:0] PWDATA,
  input  logic [DAT_W-1:0] PRDATA,
  input  logic             PREADY,
  input  logic             PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [15:0] wait_nxt;
  logic        timeout_hit;

  assign wait_nxt    = wait_cnt + 16'd1;
  assign timeout_hit = TO_EN && (wait_nxt == TO_LIM);

  // Held low during reset so no command can be taken on a reset edge.
  assign cmd_ready = (state == IDLE) && !PRESET;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE   <= cmd_write;
            PADDR    <= cmd_addr;
            PWDATA   <= cmd_wdata;
            wait_cnt <= '0;
            PSEL     <= 1'b1;
            PENABLE  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            // A completion on the same cycle the limit would be hit wins.
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_nxt;
            if (timeout_hit) begin
              PSEL        <= 1'b0;
              PENABLE     <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              state       <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
